// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline branch predictor.
//   XLEN        : default address/data width
//   BTB_TAG_W   : default tag width stored in a BTB entry
//   PC_INC      : sequential fetch increment
//   ctr_t       : 2-bit direction counter encodings (SNT/WNT/WT/ST)
//   btb_entry_t : one BTB slot {valid, tag, target, ctr, jmp}
// btb_entry_t field widths come from XLEN and BTB_TAG_W here, so the
// predictor's XLEN and TAG_W parameters must match these values.
package riscv_pkg;

  localparam int XLEN      = 32;
  localparam int BTB_TAG_W = 10;

  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic                 valid;
    logic [BTB_TAG_W-1:0] tag;
    logic [XLEN-1:0]      target;
    ctr_t                 ctr;
    logic                 jmp;
  } btb_entry_t;

  function automatic ctr_t ctr_inc(input ctr_t c);
    return (c == ST) ? ST : ctr_t'(c + 2'd1);
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    return (c == SNT) ? SNT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/btb_table.sv
// BTB storage array.
//   clk, rst          : clock, asynchronous active-low reset
//   rd_idx_f_i/_o     : fetch-side combinational read port
//   rd_idx_e_i/_o     : execute-side combinational read port (training)
//   we_i, wr_idx_i,
//   wr_entry_i        : synchronous write port
// Reads return pre-write contents; a write lands at the clock edge.
module btb_table
  import riscv_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_f_i,
  output btb_entry_t       rd_entry_f_o,
  input  logic [IDX_W-1:0] rd_idx_e_i,
  output btb_entry_t       rd_entry_e_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  btb_entry_t       wr_entry_i
);

  localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0,
                                         ctr: WNT, jmp: 1'b0};

  btb_entry_t mem_q [ENTRIES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) mem_q[i] <= RESET_ENTRY;
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_entry_i;
    end
  end

  assign rd_entry_f_o = mem_q[rd_idx_f_i];
  assign rd_entry_e_o = mem_q[rd_idx_e_i];

endmodule

// File: rtl/btb_predictor.sv
// Branch target buffer with 2-bit direction counters for the 5-stage RV32I
// pipeline. Predicts in F, carries the prediction through D and E under the
// hazard unit's stall/flush, checks it in E and trains the table.
//   clk, rst                     : clock, asynchronous active-low reset
//   pc_f -> pred_taken_f,
//           pred_pc_f            : fetch lookup
//   stall_d, flush_d, flush_e    : hazard-unit controls for D/E registers
//   resolve_valid_e, is_cti_e,
//   is_jump_e, taken_e, target_e,
//   pc_e                         : resolved outcome of the E instruction
//   mispredict_e, redirect_pc_e  : fetch redirect
// Optional macro BTB_STATS_EN adds stat_lookups/stat_hits/stat_mispredicts
// (32-bit saturating counters).
module btb_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int TAG_W   = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_f,
  output logic            pred_taken_f,
  output logic [XLEN-1:0] pred_pc_f,
  input  logic            stall_d,
  input  logic            flush_d,
  input  logic            flush_e,
  input  logic            resolve_valid_e,
  input  logic            is_cti_e,
  input  logic            is_jump_e,
  input  logic            taken_e,
  input  logic [XLEN-1:0] target_e,
  input  logic [XLEN-1:0] pc_e,
  output logic            mispredict_e,
  output logic [XLEN-1:0] redirect_pc_e
`ifdef BTB_STATS_EN
  ,
  output logic [31:0]     stat_lookups,
  output logic [31:0]     stat_hits,
  output logic [31:0]     stat_mispredicts
`endif
);

  import riscv_pkg::*;

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  btb_entry_t       ent_f, ent_e, wr_entry_d;
  logic             wr_en_d;
  logic             hit_f, hit_e, actual_taken_e;

  logic             fd_taken_q, de_taken_q;
  logic [XLEN-1:0]  fd_target_q, de_target_q;

  assign idx_f = pc_f[2 +: IDX_W];
  assign tag_f = pc_f[2+IDX_W +: TAG_W];
  assign idx_e = pc_e[2 +: IDX_W];
  assign tag_e = pc_e[2+IDX_W +: TAG_W];

  btb_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_table (
    .clk          (clk),
    .rst          (rst),
    .rd_idx_f_i   (idx_f),
    .rd_entry_f_o (ent_f),
    .rd_idx_e_i   (idx_e),
    .rd_entry_e_o (ent_e),
    .we_i         (wr_en_d),
    .wr_idx_i     (idx_e),
    .wr_entry_i   (wr_entry_d)
  );

  assign hit_f        = ent_f.valid && (ent_f.tag == tag_f);
  assign pred_taken_f = hit_f && (ent_f.jmp || ent_f.ctr[1]);
  assign pred_pc_f    = pred_taken_f ? ent_f.target : pc_f + PC_INC;

  // Flush wins over stall in D; E has no stall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fd_taken_q  <= 1'b0;
      fd_target_q <= '0;
      de_taken_q  <= 1'b0;
      de_target_q <= '0;
    end else begin
      if (flush_d) begin
        fd_taken_q  <= 1'b0;
        fd_target_q <= '0;
      end else if (!stall_d) begin
        fd_taken_q  <= pred_taken_f;
        fd_target_q <= ent_f.target;
      end
      if (flush_e) begin
        de_taken_q  <= 1'b0;
        de_target_q <= '0;
      end else begin
        de_taken_q  <= fd_taken_q;
        de_target_q <= fd_target_q;
      end
    end
  end

  assign actual_taken_e = is_cti_e && taken_e;
  assign mispredict_e   = resolve_valid_e &&
                          ((de_taken_q != actual_taken_e) ||
                           (de_taken_q && taken_e && (de_target_q != target_e)));
  assign redirect_pc_e  = actual_taken_e ? target_e : pc_e + PC_INC;

  assign hit_e = ent_e.valid && (ent_e.tag == tag_e);

  always_comb begin
    wr_en_d    = 1'b0;
    wr_entry_d = ent_e;
    if (resolve_valid_e) begin
      if (is_cti_e) begin
        if (hit_e) begin
          wr_en_d = 1'b1;
          if (taken_e) begin
            wr_entry_d.ctr    = ctr_inc(ent_e.ctr);
            wr_entry_d.target = target_e;
          end else begin
            wr_entry_d.ctr    = ctr_dec(ent_e.ctr);
          end
          if (is_jump_e) begin
            wr_entry_d.ctr = ST;
            wr_entry_d.jmp = 1'b1;
          end
        end else if (taken_e) begin
          wr_en_d           = 1'b1;
          wr_entry_d.valid  = 1'b1;
          wr_entry_d.tag    = tag_e;
          wr_entry_d.target = target_e;
          wr_entry_d.ctr    = is_jump_e ? ST : WT;
          wr_entry_d.jmp    = is_jump_e;
        end
      end else if (de_taken_q && hit_e) begin
        // Predicted taken on something that is not a branch: drop the alias.
        wr_en_d          = 1'b1;
        wr_entry_d.valid = 1'b0;
      end
    end
  end

`ifdef BTB_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      if (!stall_d && (stat_lookups != '1))        stat_lookups     <= stat_lookups + 32'd1;
      if (!stall_d && hit_f && (stat_hits != '1))  stat_hits        <= stat_hits + 32'd1;
      if (mispredict_e && (stat_mispredicts != '1)) stat_mispredicts <= stat_mispredicts + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_btb_predictor.sv
module tb_btb_predictor;

  localparam logic [31:0] NF  = 32'h0000_3000;  // fetch PC that never hits
  localparam logic [31:0] NFP = 32'h0000_3004;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic [31:0] pred_pc_f;
  logic        stall_d, flush_d, flush_e;
  logic        resolve_valid_e, is_cti_e, is_jump_e, taken_e;
  logic [31:0] target_e, pc_e;
  logic        mispredict_e;
  logic [31:0] redirect_pc_e;
`ifdef BTB_STATS_EN
  logic [31:0] stat_lookups, stat_hits, stat_mispredicts;
`endif

  always #5 clk = ~clk;

  btb_predictor #(.XLEN(32), .ENTRIES(16), .TAG_W(10)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc_f            (pc_f),
    .pred_taken_f    (pred_taken_f),
    .pred_pc_f       (pred_pc_f),
    .stall_d         (stall_d),
    .flush_d         (flush_d),
    .flush_e         (flush_e),
    .resolve_valid_e (resolve_valid_e),
    .is_cti_e        (is_cti_e),
    .is_jump_e       (is_jump_e),
    .taken_e         (taken_e),
    .target_e        (target_e),
    .pc_e            (pc_e),
    .mispredict_e    (mispredict_e),
    .redirect_pc_e   (redirect_pc_e)
`ifdef BTB_STATS_EN
    ,
    .stat_lookups    (stat_lookups),
    .stat_hits       (stat_hits),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  typedef struct {
    logic [31:0] pcf;
    logic        st, fd, fe, rv, cti, jmp, tk;
    logic [31:0] pce, tgt;
    logic        ept;
    logic [31:0] epc;
    logic        emis;
    logic [31:0] ered;
  } vec_t;

  typedef struct {
    int          id;
    logic        ept;
    logic [31:0] epc;
    logic        emis;
    logic [31:0] ered;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(logic [31:0] pcf, logic st, logic fd, logic fe,
                              logic rv, logic cti, logic jmp, logic tk,
                              logic [31:0] pce, logic [31:0] tgt,
                              logic ept, logic [31:0] epc, logic emis, logic [31:0] ered);
    vec_t v;
    v.pcf = pcf; v.st = st; v.fd = fd; v.fe = fe;
    v.rv = rv; v.cti = cti; v.jmp = jmp; v.tk = tk;
    v.pce = pce; v.tgt = tgt;
    v.ept = ept; v.epc = epc; v.emis = emis; v.ered = ered;
    return v;
  endfunction

  // Fetch-only cycle: nothing resolving, pc_e=0 so redirect is 4.
  function automatic vec_t fo(logic [31:0] pcf, logic ept, logic [31:0] epc);
    return mk(pcf, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, ept, epc, 1'b0, 32'h4);
  endfunction

  task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL vec%0d %s: got %h expected %h", id, name, act, exp);
      n_err++;
    end
  endtask

  task automatic drive_idle();
    stall_d = 0; flush_d = 0; flush_e = 0;
    resolve_valid_e = 0; is_cti_e = 0; is_jump_e = 0; taken_e = 0;
    target_e = 0; pc_e = 0; pc_f = NF;
  endtask

  task automatic apply(input int id, input vec_t v);
    exp_t e, got;
    @(posedge clk); #1;
    pc_f = v.pcf; stall_d = v.st; flush_d = v.fd; flush_e = v.fe;
    resolve_valid_e = v.rv; is_cti_e = v.cti; is_jump_e = v.jmp; taken_e = v.tk;
    pc_e = v.pce; target_e = v.tgt;
    e.id = id; e.ept = v.ept; e.epc = v.epc; e.emis = v.emis; e.ered = v.ered;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    n_vec++;
    chk(got.id, "pred_taken_f",  {31'b0, pred_taken_f}, {31'b0, got.ept});
    chk(got.id, "pred_pc_f",     pred_pc_f,              got.epc);
    chk(got.id, "mispredict_e",  {31'b0, mispredict_e}, {31'b0, got.emis});
    chk(got.id, "redirect_pc_e", redirect_pc_e,          got.ered);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    drive_idle();
    pc_f = 32'h100;
    rst  = 1'b0;
    #3;
    n_vec++;
    chk(-1, "reset pred_taken_f", {31'b0, pred_taken_f}, 32'h0);
    chk(-1, "reset pred_pc_f",    pred_pc_f,             32'h104);
    chk(-1, "reset mispredict_e", {31'b0, mispredict_e}, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    // Cold branch, training, hysteresis
    vecs.push_back(fo(32'h200, 0, 32'h204));
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,1, 32'h200, 32'h180, 0, NFP, 1, 32'h180));
    vecs.push_back(fo(32'h200, 1, 32'h180));
    vecs.push_back(fo(NF, 0, NFP));
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,1, 32'h200, 32'h180, 0, NFP, 0, 32'h180));
    vecs.push_back(fo(32'h200, 1, 32'h180));
    vecs.push_back(fo(NF, 0, NFP));
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,0, 32'h200, 32'h180, 0, NFP, 1, 32'h204));
    vecs.push_back(fo(32'h200, 1, 32'h180));
    vecs.push_back(fo(NF, 0, NFP));
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,0, 32'h200, 32'h180, 0, NFP, 1, 32'h204));
    vecs.push_back(fo(32'h200, 0, 32'h204));
    vecs.push_back(fo(NF, 0, NFP));
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,0, 32'h200, 32'h180, 0, NFP, 0, 32'h204));
    // Alias: 0x240 shares index 0 with 0x200 but has a different tag
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,1, 32'h240, 32'h300, 0, NFP, 1, 32'h300));
    vecs.push_back(fo(32'h200, 0, 32'h204));
    vecs.push_back(fo(32'h240, 1, 32'h300));
    // Jump allocation, then a non-CTI hit that invalidates it
    vecs.push_back(mk(NF, 0,0,0, 1,1,1,1, 32'h404, 32'h800, 0, NFP, 1, 32'h800));
    vecs.push_back(fo(32'h404, 1, 32'h800));
    vecs.push_back(fo(NF, 0, NFP));
    vecs.push_back(mk(NF, 0,0,0, 1,0,0,0, 32'h404, 32'h0, 0, NFP, 1, 32'h408));
    vecs.push_back(fo(32'h404, 0, 32'h408));
    // Not-valid resolve with predicted-taken prediction in E
    vecs.push_back(fo(32'h240, 1, 32'h300));
    vecs.push_back(fo(NF, 0, NFP));
    vecs.push_back(mk(NF, 0,0,0, 0,1,0,0, 32'h240, 32'h300, 0, NFP, 0, 32'h244));
    // Address-space wrap
    vecs.push_back(mk(32'hFFFF_FFFC, 0,0,0, 0,0,0,0, 32'hFFFF_FFFC, 32'h0, 0, 32'h0, 0, 32'h0));
    // Right direction, wrong target
    vecs.push_back(fo(32'h240, 1, 32'h300));
    vecs.push_back(fo(NF, 0, NFP));
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,1, 32'h240, 32'h340, 0, NFP, 1, 32'h340));
    vecs.push_back(fo(32'h240, 1, 32'h340));
    // Stall D twice with E flushed, then release
    vecs.push_back(fo(32'h240, 1, 32'h340));
    vecs.push_back(mk(NF, 1,0,1, 0,0,0,0, 32'h0, 32'h0, 0, NFP, 0, 32'h4));
    vecs.push_back(mk(NF, 1,0,1, 1,1,0,0, 32'h240, 32'h340, 0, NFP, 0, 32'h244));
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,1, 32'h240, 32'h340, 0, NFP, 1, 32'h340));
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,1, 32'h240, 32'h340, 0, NFP, 0, 32'h340));
    // flush_d beats stall_d
    vecs.push_back(fo(32'h240, 1, 32'h340));
    vecs.push_back(mk(32'h240, 1,1,0, 0,0,0,0, 32'h0, 32'h0, 1, 32'h340, 0, 32'h4));
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,1, 32'h240, 32'h340, 0, NFP, 0, 32'h340));
    vecs.push_back(mk(NF, 0,0,0, 1,1,0,1, 32'h240, 32'h340, 0, NFP, 1, 32'h340));
    vecs.push_back(fo(32'h240, 1, 32'h340));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Asynchronous reset in the middle of a cycle discards the table
    #2;
    rst = 1'b0;
    #1;
    n_vec++;
    chk(100, "midreset pred_taken_f", {31'b0, pred_taken_f}, 32'h0);
    chk(100, "midreset pred_pc_f",    pred_pc_f,             32'h244);
    chk(100, "midreset mispredict_e", {31'b0, mispredict_e}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    apply(101, mk(32'h240, 0,0,0, 1,1,0,1, 32'h240, 32'h340, 0, 32'h244, 1, 32'h340));

`ifdef BTB_STATS_EN
    @(posedge clk); #1;
    drive_idle();
    stall_d = 1;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    resolve_valid_e = 1; is_cti_e = 1; taken_e = 1; pc_e = 32'h200; target_e = 32'h180;
    @(posedge clk); #1;
    pc_e = 32'h204; target_e = 32'h500;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      resolve_valid_e = 0; is_cti_e = 0; taken_e = 0;
      stall_d = 0;
      pc_f = (i < 4) ? 32'h200 : NF;
    end
    @(posedge clk); #1;
    stall_d = 1;
    n_vec++;
    chk(200, "stat_lookups",     stat_lookups,     32'd10);
    chk(200, "stat_hits",        stat_hits,        32'd4);
    chk(200, "stat_mispredicts", stat_mispredicts, 32'd2);
`endif

    if (sb.size() != 0) begin
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
      n_err++;
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
